// File: rtl/dcm_sup_pkg.sv
// Shared encoding, counter width and parameter defaults for the DCM supervisor.
// Pure declarations; no logic and no latency.
package dcm_sup_pkg;

  localparam int CNT_W = 20;

  localparam int DEF_RST_CYCLES    = 8;
  localparam int DEF_LOCK_TIMEOUT  = 1000000;
  localparam int DEF_SETTLE_CYCLES = 256;
  localparam int DEF_MAX_RETRY     = 15;

  localparam logic [2:0] ST_PULSE     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

endpackage

// File: rtl/dcm_sup_sync2.sv
// Two-flop synchronizer with asynchronous clear, WIDTH bits wide.
// Latency 2 clk edges; no flow control.
module dcm_sup_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_supervisor.sv
// Sequences DCM reset, waits for a settled clean lock, then releases system reset; retries or faults.
// Lock inputs add 2 cycles of synchronizer latency; every output is a flop.
module dcm_supervisor
  import dcm_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       CLKIN,
  input  logic       RST_N,
  input  logic       DCM_LOCKED,
  input  logic [7:0] DCM_STATUS,
  output logic       DCM_RST,
  output logic       SYS_RST_N,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
  output logic       FAULT
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees clean lock is counted as clean cycle one.
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       RETRY_MX = 4'(MAX_RETRY);

  logic             rst_int_n;
  logic [1:0]       in_s;
  logic             clean;
  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry_nx;
  logic [7:0]       loss_nx;
  logic             unused_status;

  assign unused_status = ^{DCM_STATUS[7:3], DCM_STATUS[1:0]};

  dcm_sup_sync2 #(.WIDTH(1)) u_rst_sync (
    .clk   (CLKIN),
    .clr_n (RST_N),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  dcm_sup_sync2 #(.WIDTH(2)) u_in_sync (
    .clk   (CLKIN),
    .clr_n (rst_int_n),
    .d     ({DCM_STATUS[2], DCM_LOCKED}),
    .q     (in_s)
  );

  assign clean = in_s[0] & ~in_s[1];

  always_comb begin
    state_nx = state;
    retry_nx = RETRY_CNT;
    loss_nx  = LOSS_CNT;
    case (state)
      ST_PULSE: begin
        if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (clean) begin
          state_nx = ST_SETTLE;
        end else if (cnt == TMO_LAST) begin
          if (RETRY_CNT == RETRY_MX) begin
            state_nx = ST_FAULT;
          end else begin
            state_nx = ST_PULSE;
            retry_nx = RETRY_CNT + 4'd1;
          end
        end
      end
      ST_SETTLE: begin
        if (!clean) begin
          state_nx = ST_WAIT_LOCK;
        end else if (cnt == SET_LAST) begin
          state_nx = ST_RUN;
          retry_nx = 4'd0;
        end
      end
      ST_RUN: begin
        if (!clean) begin
          state_nx = ST_PULSE;
          if (LOSS_CNT != 8'hFF) loss_nx = LOSS_CNT + 8'd1;
        end
      end
      ST_FAULT: begin
        state_nx = ST_FAULT;
      end
      default: state_nx = ST_PULSE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLKIN or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= ST_PULSE;
      cnt       <= '0;
      DCM_RST   <= 1'b1;
      SYS_RST_N <= 1'b0;
      RETRY_CNT <= 4'd0;
      LOSS_CNT  <= 8'd0;
      FAULT     <= 1'b0;
    end else begin
      state     <= state_nx;
      RETRY_CNT <= retry_nx;
      LOSS_CNT  <= loss_nx;
      DCM_RST   <= (state_nx == ST_PULSE);
      SYS_RST_N <= (state_nx == ST_RUN);
      FAULT     <= (state_nx == ST_FAULT);
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state == ST_PULSE || state == ST_WAIT_LOCK || state == ST_SETTLE) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dcm_supervisor.sv
// Directed bench for dcm_supervisor: a timed vector table plus hand-built corner sequences.
module tb_dcm_supervisor;

  logic       CLKIN;
  logic       RST_N;
  logic       DCM_LOCKED;
  logic [7:0] DCM_STATUS;
  logic       DCM_RST;
  logic       SYS_RST_N;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;
  logic       FAULT;

  int n_cmp;
  int n_bad;

  dcm_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (64),
    .SETTLE_CYCLES (16),
    .MAX_RETRY     (2)
  ) dut (
    .CLKIN      (CLKIN),
    .RST_N      (RST_N),
    .DCM_LOCKED (DCM_LOCKED),
    .DCM_STATUS (DCM_STATUS),
    .DCM_RST    (DCM_RST),
    .SYS_RST_N  (SYS_RST_N),
    .RETRY_CNT  (RETRY_CNT),
    .LOSS_CNT   (LOSS_CNT),
    .FAULT      (FAULT)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  typedef struct packed {
    int   adv;
    logic locked;
    logic stat2;
    logic e_dcm;
    logic e_sys;
    int   e_retry;
    int   e_loss;
    logic e_fault;
  } vec_t;

  vec_t tbl [18];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLKIN);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int dcm, input int sys,
                           input int retry, input int loss, input int fault);
    chk({tag, ".dcm_rst"},   int'(DCM_RST),   dcm);
    chk({tag, ".sys_rst_n"}, int'(SYS_RST_N), sys);
    chk({tag, ".retry_cnt"}, int'(RETRY_CNT), retry);
    chk({tag, ".loss_cnt"},  int'(LOSS_CNT),  loss);
    chk({tag, ".fault"},     int'(FAULT),     fault);
  endtask

  task automatic wait_sys(input logic v, input int budget, input string nm);
    int k;
    k = 0;
    while (SYS_RST_N !== v && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (SYS_RST_N !== v) begin
      n_bad++;
      $display("FAIL %s: sys_rst_n=%0b after %0d cycles, expected %0b", nm, SYS_RST_N, k, v);
    end
  endtask

  // Asserts RST_N mid-cycle, checks the async response, then releases on a known edge (t = 0).
  task automatic do_reset(input string tag, input logic lock_at_release);
    #3;
    RST_N = 1'b0;
    #1;
    check_all(tag, 1, 0, 0, 0, 0);
    DCM_LOCKED = lock_at_release;
    DCM_STATUS = 8'h00;
    tick(3);
    RST_N = 1'b1;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    RST_N      = 1'b0;
    DCM_LOCKED = 1'b0;
    DCM_STATUS = 8'h00;

    // adv, inputs applied after the check, expected dcm/sys/retry/loss/fault
    tbl[0]  = '{5,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[2]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[4]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[5]  = '{6,  1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[6]  = '{2,  1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[7]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
    tbl[8]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
    tbl[9]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[10] = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
    tbl[11] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[12] = '{7,  1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[13] = '{2,  1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[14] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0};
    tbl[15] = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
    tbl[16] = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
    tbl[17] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0};

    tick(3);
    check_all("in_reset", 1, 0, 0, 0, 0);
    RST_N = 1'b1;

    // Bring-up, lock loss in RUN and CLKFX stop, all timed from reset release.
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].adv);
      check_all($sformatf("row%0d", i), int'(tbl[i].e_dcm), int'(tbl[i].e_sys),
                tbl[i].e_retry, tbl[i].e_loss, int'(tbl[i].e_fault));
      DCM_LOCKED = tbl[i].locked;
      DCM_STATUS = {5'b0, tbl[i].stat2, 2'b0};
    end

    // One-cycle lock glitch at settle count 10.
    do_reset("rst_in_run", 1'b0);
    tick(6);
    chk("glitch.wait_dcm", int'(DCM_RST), 0);
    DCM_LOCKED = 1'b1;
    tick(11);
    DCM_LOCKED = 1'b0;
    tick(1);
    DCM_LOCKED = 1'b1;
    tick(6);
    chk("glitch.no_early_release", int'(SYS_RST_N), 0);
    tick(11);
    chk("glitch.before_release", int'(SYS_RST_N), 0);
    tick(1);
    chk("glitch.release", int'(SYS_RST_N), 1);
    chk("glitch.retry", int'(RETRY_CNT), 0);

    // Async reset while in SETTLE.
    do_reset("rst_after_glitch", 1'b1);
    tick(12);
    chk("settle.dcm_rst", int'(DCM_RST), 0);
    chk("settle.sys_rst_n", int'(SYS_RST_N), 0);
    do_reset("rst_in_settle", 1'b0);

    // Timeout, two retries, then FAULT.
    tick(69);
    chk("tmo1.before_dcm", int'(DCM_RST), 0);
    chk("tmo1.before_retry", int'(RETRY_CNT), 0);
    tick(1);
    chk("tmo1.dcm", int'(DCM_RST), 1);
    chk("tmo1.retry", int'(RETRY_CNT), 1);
    tick(3);
    chk("tmo1.pulse_end", int'(DCM_RST), 1);
    tick(1);
    chk("tmo1.pulse_fall", int'(DCM_RST), 0);
    tick(63);
    chk("tmo2.before_dcm", int'(DCM_RST), 0);
    tick(1);
    chk("tmo2.dcm", int'(DCM_RST), 1);
    chk("tmo2.retry", int'(RETRY_CNT), 2);
    tick(4);
    chk("tmo2.pulse_fall", int'(DCM_RST), 0);
    tick(63);
    chk("tmo3.before_fault", int'(FAULT), 0);
    tick(1);
    check_all("tmo3", 0, 0, 2, 0, 1);
    DCM_LOCKED = 1'b1;
    tick(100);
    check_all("fault_hold", 0, 0, 2, 0, 1);
    do_reset("rst_in_fault", 1'b1);

    // 256 lock losses saturate LOSS_CNT at 255.
    wait_sys(1'b1, 60, "loss.first_run");
    for (int i = 0; i < 256; i++) begin
      DCM_LOCKED = 1'b0;
      wait_sys(1'b0, 10, "loss.drop");
      DCM_LOCKED = 1'b1;
      wait_sys(1'b1, 60, "loss.relock");
      if (i == 0)   chk("loss.first", int'(LOSS_CNT), 1);
      if (i == 254) chk("loss.255th", int'(LOSS_CNT), 255);
      if (i == 255) chk("loss.saturated", int'(LOSS_CNT), 255);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcm_supervisor.md
DCM_SUPERVISOR -- requirements
Module: dcm_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 8: CLKIN cycles DCM_RST is held high per reset pulse; minimum 3.
REQ-002 Parameter LOCK_TIMEOUT, default 1000000: CLKIN cycles allowed from DCM_RST release to lock.
REQ-003 Parameter SETTLE_CYCLES, default 256: consecutive CLKIN cycles of clean lock required before releasing system reset.
REQ-004 Parameter MAX_RETRY, default 15: failed lock attempts tolerated before FAULT; 1..15.
REQ-005 CLKIN  in  1: supervisor clock, the DCM input clock (24 MHz).
REQ-006 RST_N  in  1: reset, asynchronous, active-low.
REQ-007 DCM_LOCKED  in  1: LOCKED from the DCM instance; asynchronous to CLKIN.
REQ-008 DCM_STATUS  in  8: STATUS from the DCM instance; only bit 2 (CLKFX stopped) is used.
REQ-009 DCM_RST  out  1: drives the DCM RST input, active-high.
REQ-010 SYS_RST_N  out  1: active-low reset for logic clocked by CLKFX; CLKFX-domain consumers synchronize its deassertion themselves.
REQ-011 RETRY_CNT  out  4: failed lock attempts since last entry to RUN.
REQ-012 LOSS_CNT  out  8: lock losses during RUN since RST_N, saturating at 255.
REQ-013 FAULT  out  1: high when retries are exhausted.

Function
REQ-014 DCM_LOCKED and DCM_STATUS[2] shall each pass through a 2-flop synchronizer; all decisions use the synchronized values, which adds 2 cycles of latency.
REQ-015 "Clean lock" shall mean synchronized LOCKED = 1 and synchronized STATUS[2] = 0.
REQ-016 The FSM states shall be PULSE, WAIT_LOCK, SETTLE, RUN and FAULT; one shared 20-bit cycle counter shall be cleared on every state change.
REQ-017 PULSE: DCM_RST = 1; after RST_CYCLES cycles the FSM shall go to WAIT_LOCK.
REQ-018 WAIT_LOCK: DCM_RST = 0; clean lock shall go to SETTLE.
REQ-019 WAIT_LOCK timeout: when the counter reaches LOCK_TIMEOUT-1 without clean lock, if RETRY_CNT = MAX_RETRY the FSM shall go to FAULT; otherwise it shall increment RETRY_CNT and go to PULSE.
REQ-020 SETTLE: any cycle without clean lock shall return the FSM to WAIT_LOCK, with the timeout restarted and RETRY_CNT unchanged.
REQ-021 SETTLE: SETTLE_CYCLES consecutive clean cycles shall go to RUN.
REQ-022 On entry to RUN, SYS_RST_N shall rise registered in the same cycle as the state change, and RETRY_CNT shall clear to 0.
REQ-023 RUN: loss of clean lock shall drive SYS_RST_N = 0 on the next edge, increment LOSS_CNT (saturating), and go to PULSE.
REQ-024 SYS_RST_N shall be 1 only in RUN.
REQ-025 FAULT: DCM_RST = 0, SYS_RST_N = 0, FAULT = 1; FAULT is terminal until RST_N is asserted, and DCM lock inputs are ignored there.
REQ-026 All outputs shall be registered; no combinational path shall exist from any input to any output.

Reset
REQ-027 While RST_N = 0: state = PULSE, counter = 0, synchronizers = 0, DCM_RST = 1, SYS_RST_N = 0, RETRY_CNT = 0, LOSS_CNT = 0, FAULT = 0.
REQ-028 RST_N asserted mid-operation, in any state including FAULT, shall take effect immediately and restart the full sequence after release.
REQ-029 Reset assertion shall be asynchronous and deassertion synchronous to CLKIN: an internal 2-flop reset synchronizer generates the release.

Structure
REQ-030 Package dcm_sup_pkg shall hold the state encoding, the counter width (20), and the parameter defaults.
REQ-031 Sub-module dcm_sup_sync2 (2-flop synchronizer with async clear, width parameter) shall be instantiated for the lock/status inputs and for the reset release.
REQ-032 The block shall sit alongside the DCM wrapper; DCM_RST connects to its RST input, and DCM_LOCKED/DCM_STATUS connect to its LOCKED/STATUS outputs.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=64, SETTLE_CYCLES=16, MAX_RETRY=2)
REQ-033 Nominal bring-up: release RST_N, then assert LOCKED 10 cycles after DCM_RST falls -> DCM_RST high exactly 4 cycles; SYS_RST_N rises 2+16 cycles after LOCKED; RETRY_CNT = 0.
REQ-034 Timeout and retry: hold LOCKED = 0 -> DCM_RST re-pulses every 4+64 cycles; RETRY_CNT goes 1 then 2; on the third timeout FAULT = 1 and DCM_RST stays 0 permanently.
REQ-035 Settle glitch: drop LOCKED for 1 cycle at settle count 10 -> state returns to WAIT_LOCK; SYS_RST_N stays 0; release occurs 18 cycles after LOCKED returns.
REQ-036 Lock loss in RUN: drop LOCKED -> SYS_RST_N = 0 within 3 cycles; LOSS_CNT = 1; DCM_RST pulses 4 cycles; relock restores RUN with RETRY_CNT = 0.
REQ-037 CLKFX stop: set STATUS[2] = 1 in RUN with LOCKED = 1 -> same response as REQ-036.
REQ-038 Async reset in FAULT and mid-SETTLE: assert RST_N low between clock edges -> all outputs reach reset values before the next edge; 256 lock losses -> LOSS_CNT = 255.
